tag_release_queue: RTL
======================

# tag_release_queue

Return-side companion to the rename free list. Retirement hands back up to two physical tags per cycle. The free list accepts only one tag write per cycle. This block buffers the returned tags in order and drains them into the free list's single write port at one tag per cycle. It applies backpressure to retirement when its buffer cannot take a full pair.

## Interface
Parameters:
- WIDTH, 128, number of physical tags in the design. Tag width is TW = $clog2(WIDTH)+1 bits.
- DEPTH, 8, buffer entries. Must be a power of two and at least 4.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- release_valid_0  in  1  slot 0 carries a tag to release.
- release_tag_0  in  TW  tag for slot 0.
- release_valid_1  in  1  slot 1 carries a tag to release. Slot 1 is younger than slot 0.
- release_tag_1  in  TW  tag for slot 1.
- release_ready  out  1  buffer can accept two tags this cycle.
- write_tag  out  1  to the free list: push write_tag_source this cycle.
- write_tag_source  out  TW  tag being returned to the free list.
- num_pending  out  $clog2(DEPTH)+1  number of tags currently buffered.

## Operation
- Storage is a circular buffer of DEPTH entries, each TW bits, with read pointer rd_ptr, write pointer wr_ptr and occupancy count.
- Both pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- count ranges 0..DEPTH and is exported as num_pending.
- release_ready = (DEPTH - count) >= 2, computed from registered count only. It does not credit a same-cycle drain.
- Enqueue happens only when release_ready=1. The number of tags pushed, n_push, is release_valid_0 + release_valid_1.
  - Both slots valid: tag_0 is written at wr_ptr, tag_1 at wr_ptr+1, and wr_ptr advances by 2.
  - Only slot 0 valid: tag_0 is written at wr_ptr, and wr_ptr advances by 1.
  - Only slot 1 valid: tag_1 is written at wr_ptr, and wr_ptr advances by 1. No bubble entry is created.
- Any valid while release_ready=0 is dropped and buffer state is unchanged. A simulation assertion fires, because this is an upstream protocol violation.
- Drain: write_tag = (count != 0) and write_tag_source = buf[rd_ptr].
  - write_tag_source is forced to 0 when count == 0.
  - The free list has no backpressure, so every cycle with write_tag=1 pops one entry: rd_ptr+1 and n_pop=1.
- Count update: count_next = count + n_push - n_pop, with n_push in {0,1,2} and n_pop in {0,1}.
- Simultaneous push and pop is legal in every state, including count==DEPTH-2 with a pair push and a pop, which gives DEPTH-1.
- Tag values are passed through unmodified. No duplicate or range checking is done here.
- Reset: rd_ptr=0, wr_ptr=0, count=0, buffer contents cleared to 0.
  - Reset overrides any same-cycle push or pop.
  - Tags buffered when reset asserts are discarded. The free list re-initialises on the same reset.

## Timing
- Outputs after reset: write_tag=0, write_tag_source=0, num_pending=0, release_ready=1.
- Latency: a tag accepted at posedge N is presented on write_tag/write_tag_source during cycle N+1 at the earliest. There is no same-cycle bypass from input to output.
- Drain order is strictly FIFO: slot 0 of a pair exits one cycle before slot 1 of the same pair.
- Sustained throughput: 1 tag per cycle out, up to 2 tags per cycle in.
  - Continuous pair input fills the buffer at net +1 per cycle.
  - release_ready drops once count reaches DEPTH-1.
- release_ready, write_tag, write_tag_source and num_pending depend only on registered state. They are free of combinational paths from the release_* inputs.

## Test plan
- Reset, then idle: write_tag=0, write_tag_source=0, num_pending=0 and release_ready=1 held for 10 cycles.
- Single pair: push (5, 9) in one cycle, then idle.
  - Next cycle: write_tag=1, source=5, num_pending=2.
  - Following cycle: source=9, num_pending=1.
  - Then write_tag=0, num_pending=0.
- Slot-1-only push: release_valid_1=1 with tag 0x3A and release_valid_0=0. Exactly one entry is buffered, and 0x3A appears next cycle. No zero tag is emitted.
- Backpressure, DEPTH=8: pairs pushed every cycle from empty.
  - count rises 2,3,4,5,6,7.
  - release_ready=0 at count 7.
  - Drain resumes release_ready=1 at count 6.
  - Output sequence matches input order exactly, with no loss or duplication.
- Wrap-around: stream 40 tags (0..39) in mixed single and pair pushes. All 40 emerge in order after several rd_ptr/wr_ptr wraps.
- Reset mid-operation: buffer holding 5 tags, with reset asserted concurrently with a pair push.
  - Next cycle: num_pending=0 and write_tag=0.
  - Neither the old tags nor the pushed tags are ever emitted.

Source files
------------

// File: rtl/tag_release_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : tag_release_queue_if
//  Description : Bundle between retirement (release side), the tag release
//                queue and the rename free list (single write port).
//                master = retirement / free-list side, slave = the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tag_release_queue_if #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
);
  localparam int c_TW = $clog2(WIDTH) + 1;
  localparam int c_CW = $clog2(DEPTH) + 1;

  // Retirement side: up to two tags per cycle, slot 1 younger than slot 0
  logic            release_valid_0;
  logic [c_TW-1:0] release_tag_0;
  logic            release_valid_1;
  logic [c_TW-1:0] release_tag_1;
  logic            release_ready;

  // Free-list side: one tag per cycle, no backpressure
  logic            write_tag;
  logic [c_TW-1:0] write_tag_source;

  // Occupancy
  logic [c_CW-1:0] num_pending;

  modport master (
    output release_valid_0,
    output release_tag_0,
    output release_valid_1,
    output release_tag_1,
    input  release_ready,
    input  write_tag,
    input  write_tag_source,
    input  num_pending
  );

  modport slave (
    input  release_valid_0,
    input  release_tag_0,
    input  release_valid_1,
    input  release_tag_1,
    output release_ready,
    output write_tag,
    output write_tag_source,
    output num_pending
  );
endinterface
`default_nettype wire

// File: rtl/tag_release_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tag_release_queue
//  Description : In-order circular buffer between retirement (up to two
//                returned physical tags per cycle) and the free list's single
//                write port (one tag per cycle). Backpressures retirement
//                whenever fewer than two entries are free.
//  Revision    : 1.0 - initial release
// ============================================================================
module tag_release_queue #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  wire logic           clk,
  input  wire logic           reset,
  tag_release_queue_if.slave  bus
);

  localparam int c_TW = $clog2(WIDTH) + 1;
  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH) + 1;

  // Pointer arithmetic relies on DEPTH being a power of two so the pointers
  // wrap for free; a pair push needs at least a little headroom beyond 2.
  generate
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("tag_release_queue: DEPTH must be a power of two and >= 4");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_TW-1:0] r_buf [DEPTH];
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_CW-1:0] r_count;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [c_CW-1:0] w_space;
  logic            w_ready;
  logic            w_acc_0;
  logic            w_acc_1;
  logic [1:0]      w_n_push;
  logic            w_pop;
  logic            w_we_a;
  logic            w_we_b;
  logic [c_TW-1:0] w_data_a;
  logic [c_PW-1:0] w_wr_ptr_p1;
  logic [c_PW-1:0] w_wr_ptr_next;
  logic [c_PW-1:0] w_rd_ptr_next;
  logic [c_CW-1:0] w_count_next;

  // Readiness comes from registered count only; a same-cycle drain is not
  // credited, which keeps release_ready free of any input-to-output path.
  assign w_space = c_CW'(DEPTH) - r_count;
  assign w_ready = (w_space >= c_CW'(2));

  // Valids arriving while not ready are dropped here (protocol violation)
  assign w_acc_0  = w_ready & bus.release_valid_0;
  assign w_acc_1  = w_ready & bus.release_valid_1;
  assign w_n_push = {1'b0, w_acc_0} + {1'b0, w_acc_1};

  // The free list never stalls, so any buffered entry drains this cycle
  assign w_pop = (r_count != '0);

  // Port A writes at wr_ptr: slot 0 if present, else slot 1 (no bubble).
  // Port B writes slot 1 at wr_ptr+1 only when both slots are valid.
  assign w_we_a      = w_acc_0 | w_acc_1;
  assign w_we_b      = w_acc_0 & w_acc_1;
  assign w_data_a    = w_acc_0 ? bus.release_tag_0 : bus.release_tag_1;
  assign w_wr_ptr_p1 = r_wr_ptr + c_PW'(1);

  assign w_wr_ptr_next = r_wr_ptr + c_PW'(w_n_push);
  assign w_rd_ptr_next = r_rd_ptr + c_PW'(w_pop);
  assign w_count_next  = r_count + c_CW'(w_n_push) - c_CW'(w_pop);

  // --------------------------------------------------------------------------
  // Outputs: all derived from registered state
  // --------------------------------------------------------------------------
  assign bus.release_ready    = w_ready;
  assign bus.write_tag        = w_pop;
  assign bus.write_tag_source = w_pop ? r_buf[r_rd_ptr] : '0;
  assign bus.num_pending      = r_count;

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Pointer and occupancy update; reset wins over any same-cycle push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_next;
      r_wr_ptr <= w_wr_ptr_next;
      r_count  <= w_count_next;
    end
  end

  // Tag storage: up to two writes per cycle at consecutive slots
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      if (w_we_a) begin
        r_buf[r_wr_ptr] <= w_data_a;
      end
      if (w_we_b) begin
        r_buf[w_wr_ptr_p1] <= bus.release_tag_1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Simulation checks
  // --------------------------------------------------------------------------

  // Upstream must hold off while release_ready is low
  a_no_release_when_full: assert property (
    @(posedge clk) disable iff (reset)
      (bus.release_valid_0 || bus.release_valid_1) |-> bus.release_ready
  );

  // Occupancy never exceeds the storage
  a_count_in_range: assert property (
    @(posedge clk) disable iff (reset)
      r_count <= c_CW'(DEPTH)
  );

  // Count and pointer distance always agree (full wraps to distance 0)
  a_ptr_consistent: assert property (
    @(posedge clk) disable iff (reset)
      r_count[c_PW-1:0] == c_PW'(r_wr_ptr - r_rd_ptr)
  );

endmodule
`default_nettype wire
